// File: rtl/lo_freq_monitor.sv
// LO frequency monitor: counts synchronized lo_p rising edges over a 2^(BASE_LOG2+gate_sel)
// cycle window and flags loss of lo_p/lo_n complementarity during that window.
module lo_freq_monitor #(
  parameter int CNT_W     = 12,
  parameter int BASE_LOG2 = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lo_p,
  input  logic             lo_n,
  input  logic             start,
  input  logic [1:0]       gate_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             fault
);

  localparam int TW = BASE_LOG2 + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             p_meta_q, sp_q, spd_q, n_meta_q, sn_q;
  logic             rise_s, eq_s;
  logic [1:0]       gsel_q, gsel_d;
  logic [TW-1:0]    timer_q, timer_d, timer_last_s;
  logic [CNT_W-1:0] edges_q, edges_d, count_q, count_d;
  logic             eq_prev_q, eq_prev_d, fault_acc_q, fault_acc_d;
  logic             fault_q, fault_d, busy_q, busy_d, done_q, done_d;

  // Two-flop synchronizers on both LO phases plus a delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_meta_q <= 1'b0;
      sp_q     <= 1'b0;
      spd_q    <= 1'b0;
      n_meta_q <= 1'b0;
      sn_q     <= 1'b0;
    end else begin
      p_meta_q <= lo_p;
      sp_q     <= p_meta_q;
      spd_q    <= sp_q;
      n_meta_q <= lo_n;
      sn_q     <= n_meta_q;
    end
  end

  assign rise_s       = sp_q & ~spd_q;
  assign eq_s         = (sp_q == sn_q);
  assign timer_last_s = {TW{1'b1}} >> (2'd3 - gsel_q);

  // Measurement sequencing; results are captured on the final gate cycle so they are valid with done.
  always_comb begin
    state_d     = state_q;
    gsel_d      = gsel_q;
    timer_d     = timer_q;
    edges_d     = edges_q;
    eq_prev_d   = eq_prev_q;
    fault_acc_d = fault_acc_q;
    count_d     = count_q;
    fault_d     = fault_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        edges_d     = {CNT_W{1'b0}};
        timer_d     = {TW{1'b0}};
        fault_acc_d = 1'b0;
        eq_prev_d   = 1'b0;
        gsel_d      = gate_sel;
        state_d     = GATE;
      end
      GATE: begin
        // Saturate instead of wrapping when CNT_W is too narrow for the fastest LO.
        if (rise_s && (edges_q != {CNT_W{1'b1}})) begin
          edges_d = edges_q + CNT_W'(1);
        end else begin
          edges_d = edges_q;
        end
        if (eq_s && eq_prev_q) begin
          fault_acc_d = 1'b1;
        end else begin
          fault_acc_d = fault_acc_q;
        end
        eq_prev_d = eq_s;
        timer_d   = timer_q + TW'(1);
        if (timer_q == timer_last_s) begin
          state_d = DONE;
          count_d = edges_d;
          fault_d = fault_acc_d;
        end else begin
          state_d = GATE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gsel_q      <= 2'd0;
      timer_q     <= {TW{1'b0}};
      edges_q     <= {CNT_W{1'b0}};
      eq_prev_q   <= 1'b0;
      fault_acc_q <= 1'b0;
      count_q     <= {CNT_W{1'b0}};
      fault_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gsel_q      <= gsel_d;
      timer_q     <= timer_d;
      edges_q     <= edges_d;
      eq_prev_q   <= eq_prev_d;
      fault_acc_q <= fault_acc_d;
      count_q     <= count_d;
      fault_q     <= fault_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;
  assign fault = fault_q;

endmodule
